axi_read_responder: RTL

- AXI4 read-channel slave (subordinate) memory model: accepts AR requests, returns R bursts from an internal word array.
- Serves as the far end for the core's instruction/data fetch master in simulation and FPGA bring-up.
- Supports FIXED, INCR and WRAP bursts, configurable first-beat latency, and backdoor preload.

---
 rtl/axi_read_responder.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_read_responder.sv
// -----------------------------------------------------------------------------
// axi_read_responder
//
// AXI4 read-channel subordinate backed by an internal word array. Accepts one
// AR request at a time and returns the R burst (FIXED / INCR / WRAP) after a
// configurable first-beat latency. A backdoor write port preloads memory.
//
// Optional build macro: AXI_READ_RESPONDER_TRACE_EN
//   defined   -> prints one line per AR handshake and per R handshake
//   undefined -> silent; port behaviour identical in both builds
//
// Parameters
//   ID_WIDTH    AR/R transaction ID width
//   ADDR_WIDTH  byte address width
//   DATA_WIDTH  R data width (64 only: 8-byte words)
//   MEM_WORDS   number of words (power of two)
//   BASE_ADDR   byte address of word 0
//   LATENCY     clocks from AR handshake edge to first rvalid (>= 1)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   s_axi_ar*                  AR channel (id, addr, len, size, burst, valid/ready)
//   s_axi_r*                   R channel (id, data, resp, last, valid/ready)
//   mem_we/mem_waddr/mem_wdata backdoor word write, takes effect at the clock edge
// -----------------------------------------------------------------------------
module axi_read_responder #(
  parameter int unsigned                  ID_WIDTH   = 13,
  parameter int unsigned                  ADDR_WIDTH = 64,
  parameter int unsigned                  DATA_WIDTH = 64,
  parameter int unsigned                  MEM_WORDS  = 4096,
  parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR  = '0,
  parameter int unsigned                  LATENCY    = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ID_WIDTH-1:0]             s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]           s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  input  logic [2:0]                      s_axi_arsize,
  input  logic [1:0]                      s_axi_arburst,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [ID_WIDTH-1:0]             s_axi_rid,
  output logic [DATA_WIDTH-1:0]           s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic                            mem_we,
  input  logic [$clog2(MEM_WORDS)-1:0]    mem_waddr,
  input  logic [DATA_WIDTH-1:0]           mem_wdata
);

  localparam int unsigned IW    = $clog2(MEM_WORDS);
  localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS) << 3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  // Memory array; never reset so preloaded contents survive a reset.
  logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];

  // Latched request and burst progress
  logic                    r_arready;
  logic [ID_WIDTH-1:0]     r_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic [1:0]              r_resp;
  logic [7:0]              r_beat;
  logic [LAT_W-1:0]        r_lat;

  logic                    w_ar_hs;
  logic                    w_r_hs;
  logic                    w_rvalid;
  logic                    w_last;
  logic                    w_slverr;
  logic                    w_decerr;
  logic [1:0]              w_resp_chk;
  logic                    w_borrow;
  logic [ADDR_WIDTH-1:0]   w_ar_off;
  logic [ADDR_WIDTH-1:0]   w_step;
  logic [ADDR_WIDTH-1:0]   w_wrap_mask;
  logic [ADDR_WIDTH-1:0]   w_addr_inc;
  logic [ADDR_WIDTH-1:0]   w_addr_nxt;
  logic [IW-1:0]           w_idx;

  // ---------------------------------------------------------------------------
  // Handshakes and beat status
  // ---------------------------------------------------------------------------
  assign w_rvalid = (r_state == ST_BURST);
  assign w_ar_hs  = s_axi_arvalid && r_arready;
  assign w_r_hs   = w_rvalid && s_axi_rready;
  assign w_last   = (r_beat == r_len);

  // ---------------------------------------------------------------------------
  // Request checks, evaluated once at acceptance. The start offset is computed
  // with an explicit borrow so "below BASE_ADDR" needs no signed compare.
  // ---------------------------------------------------------------------------
  assign {w_borrow, w_ar_off} = {1'b0, s_axi_araddr} - {1'b0, BASE_ADDR};

  always_comb begin
    w_slverr = 1'b0;
    if (s_axi_arsize > 3'd3)
      w_slverr = 1'b1;
    if (s_axi_arburst == 2'b11)
      w_slverr = 1'b1;
    if (s_axi_arburst == BURST_WRAP &&
        !(s_axi_arlen == 8'd1 || s_axi_arlen == 8'd3 ||
          s_axi_arlen == 8'd7 || s_axi_arlen == 8'd15))
      w_slverr = 1'b1;
  end

  assign w_decerr = w_borrow || (w_ar_off >= MEM_BYTES);

  always_comb begin
    w_resp_chk = RESP_OKAY;
    if (w_slverr)
      w_resp_chk = RESP_SLVERR;
    else if (w_decerr)
      w_resp_chk = RESP_DECERR;
  end

  // ---------------------------------------------------------------------------
  // Next beat address. WRAP keeps the bits above the wrap boundary and lets
  // only the low bits roll over; illegal burst types are error bursts whose
  // address is irrelevant, so they simply follow INCR.
  // ---------------------------------------------------------------------------
  assign w_step      = ADDR_WIDTH'(1) << r_size;
  assign w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);
  assign w_addr_inc  = r_addr + w_step;

  always_comb begin
    w_addr_nxt = w_addr_inc;
    if (r_burst == BURST_FIXED)
      w_addr_nxt = r_addr;
    else if (r_burst == BURST_WRAP)
      w_addr_nxt = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
  end

  // Truncation to IW bits makes INCR bursts past the top wrap to word 0.
  assign w_idx = IW'((r_addr - BASE_ADDR) >> 3);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_ar_hs)              w_state_nxt = ST_WAIT;
      ST_WAIT:  if (r_lat == '0)          w_state_nxt = ST_BURST;
      ST_BURST: if (w_r_hs && w_last)     w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request/beat registers. arready is registered from the current state so it
  // is low in the reset cycle, low on the cycle after any AR handshake, and
  // low for the first IDLE cycle after a burst ends.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_arready <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_resp    <= '0;
      r_beat    <= '0;
      r_lat     <= '0;
    end else begin
      r_arready <= (r_state == ST_IDLE) && !w_ar_hs;

      if (w_ar_hs) begin
        r_id    <= s_axi_arid;
        r_addr  <= s_axi_araddr;
        r_len   <= s_axi_arlen;
        r_size  <= s_axi_arsize;
        r_burst <= s_axi_arburst;
        r_resp  <= w_resp_chk;
        r_beat  <= '0;
        r_lat   <= LAT_W'(LATENCY - 1);
      end

      if (r_state == ST_WAIT && r_lat != '0)
        r_lat <= r_lat - 1'b1;

      if (w_r_hs && !w_last) begin
        r_addr <= w_addr_nxt;
        r_beat <= r_beat + 8'd1;
      end
    end
  end

  // Backdoor write port; a same-cycle read still sees the previous contents.
  always_ff @(posedge clk) begin
    if (mem_we)
      r_mem[mem_waddr] <= mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Outputs. Error beats and idle cycles drive zero data.
  // ---------------------------------------------------------------------------
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = w_rvalid;
  assign s_axi_rid     = r_id;
  assign s_axi_rresp   = r_resp;
  assign s_axi_rlast   = w_rvalid && w_last;
  assign s_axi_rdata   = (w_rvalid && r_resp == RESP_OKAY) ? r_mem[w_idx] : '0;

`ifdef AXI_READ_RESPONDER_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && w_ar_hs)
      $display("AR id=%x addr=%x len=%0d size=%0d burst=%b",
               s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
    if (!reset && w_r_hs)
      $display("R id=%x addr=%x data=%x resp=%b last=%b",
               s_axi_rid, r_addr, s_axi_rdata, s_axi_rresp, s_axi_rlast);
  end
`endif

endmodule
